// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: per-bit two-flop synchroniser followed by a per-bit
// debounce counter; a bit commits after holding a new value long enough.
module switch_debouncer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_change_mask,
  output logic             sw_changed
);

  localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [CNT_W-1:0] cnt [WIDTH];

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return c + CNT_W'(1);
  endfunction

  // Stage p0/p1: metastability guard on the asynchronous switch pins
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= sw_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce stage: any agreement with the committed value restarts the count
  always_ff @(posedge clk) begin
    if (!reset) begin
      sw_stable      <= '0;
      sw_change_mask <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_p1[i] == sw_stable[i]) begin
          cnt[i]            <= '0;
          sw_change_mask[i] <= 1'b0;
        end else if (cnt[i] == CNT_LAST) begin
          sw_stable[i]      <= sync_p1[i];
          cnt[i]            <= '0;
          sw_change_mask[i] <= 1'b1;
        end else begin
          cnt[i]            <= cnt_inc(cnt[i]);
          sw_change_mask[i] <= 1'b0;
        end
      end
    end
  end

  assign sw_changed = |sw_change_mask;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with a short debounce window of 4 cycles.
module tb_switch_debouncer;

  localparam int WIDTH = 8;
  localparam int DEB   = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_stable;
  logic [WIDTH-1:0] sw_change_mask;
  logic             sw_changed;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic             rst_n;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] exp_stable;
    logic [WIDTH-1:0] exp_mask;
    logic             exp_changed;
  } vec_t;

  vec_t vecs[$];

  switch_debouncer #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk            (clk),
    .reset          (reset),
    .sw_raw         (sw_raw),
    .sw_stable      (sw_stable),
    .sw_change_mask (sw_change_mask),
    .sw_changed     (sw_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  // Drive inputs for the next edge, clock once, then sample 1 time unit later.
  task automatic step(input string name, input logic rst_n, input logic [WIDTH-1:0] raw,
                      input logic [WIDTH-1:0] exp_stable, input logic [WIDTH-1:0] exp_mask,
                      input logic exp_changed);
    reset  = rst_n;
    sw_raw = raw;
    @(posedge clk);
    #1;
    check8({name, " stable"}, sw_stable, exp_stable);
    check8({name, " mask"}, sw_change_mask, exp_mask);
    check1({name, " changed"}, sw_changed, exp_changed);
  endtask

  task automatic push(input logic rst_n, input logic [WIDTH-1:0] raw, input logic [WIDTH-1:0] st,
                      input logic [WIDTH-1:0] mk, input logic ch);
    vec_t v;
    v.rst_n = rst_n; v.raw = raw; v.exp_stable = st; v.exp_mask = mk; v.exp_changed = ch;
    vecs.push_back(v);
  endtask

  // Clean step: five edges unchanged, commit with pulse on the sixth.
  task automatic push_step(input logic [WIDTH-1:0] raw, input logic [WIDTH-1:0] old_st,
                           input logic [WIDTH-1:0] mk);
    for (int k = 0; k < 5; k++) push(1'b1, raw, old_st, 8'h00, 1'b0);
    push(1'b1, raw, raw, mk, 1'b1);
  endtask

  initial begin
    reset  = 1'b0;
    sw_raw = 8'hFF;

    for (int k = 0; k < 3; k++) push(1'b0, 8'hFF, 8'h00, 8'h00, 1'b0);
    push_step(8'h01, 8'h00, 8'h01);
    push_step(8'h00, 8'h01, 8'h01);
    push_step(8'hA5, 8'h00, 8'hA5);
    push_step(8'h25, 8'hA5, 8'h80);
    push(1'b1, 8'h25, 8'h25, 8'h00, 1'b0);

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].raw,
           vecs[i].exp_stable, vecs[i].exp_mask, vecs[i].exp_changed);

    // Bounce on bit3: 1,1,0,0 then held 1; count never reaches the window during bounce.
    step("bounce e1", 1'b1, 8'h2D, 8'h25, 8'h00, 1'b0);
    step("bounce e2", 1'b1, 8'h2D, 8'h25, 8'h00, 1'b0);
    step("bounce e3", 1'b1, 8'h25, 8'h25, 8'h00, 1'b0);
    step("bounce e4", 1'b1, 8'h25, 8'h25, 8'h00, 1'b0);
    for (int k = 5; k <= 9; k++)
      step($sformatf("bounce e%0d", k), 1'b1, 8'h2D, 8'h25, 8'h00, 1'b0);
    step("bounce commit", 1'b1, 8'h2D, 8'h2D, 8'h08, 1'b1);
    step("bounce after", 1'b1, 8'h2D, 8'h2D, 8'h00, 1'b0);

    // Reset mid-count: clear, count three edges, reset again on edge 4, then recount.
    step("rmc clear", 1'b0, 8'h01, 8'h00, 8'h00, 1'b0);
    for (int k = 1; k <= 3; k++)
      step($sformatf("rmc e%0d", k), 1'b1, 8'h01, 8'h00, 8'h00, 1'b0);
    step("rmc e4 reset", 1'b0, 8'h01, 8'h00, 8'h00, 1'b0);
    for (int k = 5; k <= 9; k++)
      step($sformatf("rmc e%0d", k), 1'b1, 8'h01, 8'h00, 8'h00, 1'b0);
    step("rmc commit", 1'b1, 8'h01, 8'h01, 8'h01, 1'b1);
    step("rmc after", 1'b1, 8'h01, 8'h01, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
